// File: rtl/vx_mem_responder_if.sv
// rtl/vx_mem_responder_if.sv - L1 memory bus request/response bundle
interface vx_mem_responder_if #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);
  logic                     mem_req_valid;
  logic                     mem_req_rw;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [DATA_SIZE*8-1:0]   mem_req_data;
  logic [DATA_SIZE-1:0]     mem_req_byteen;
  logic [TAG_WIDTH-1:0]     mem_req_tag;
  logic                     mem_req_ready;
  logic                     mem_rsp_valid;
  logic [DATA_SIZE*8-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]     mem_rsp_tag;
  logic                     mem_rsp_ready;

  // Cache arbiter side
  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  // Memory responder side
  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - line-store memory responder with fixed read latency and credit flow control (option: VX_MEM_RSP_WRITE_ACK_EN)
module vx_mem_responder #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4,
  parameter int RSP_QUEUE  = 8
) (
  input  logic              clk,
  input  logic              reset,
  vx_mem_responder_if.slave mem,
  output logic              busy
);
  localparam int LINE_W = DATA_SIZE * 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(RSP_QUEUE + 1);
  localparam int PTR_W  = $clog2(RSP_QUEUE);
  // The store read and the final queue write each account for one cycle,
  // so only LATENCY-1 register stages sit between them.
  localparam int STAGES = LATENCY - 1;

  logic [LINE_W-1:0]    store [MEM_DEPTH];
  logic [IDX_W-1:0]     idx;
  logic                 req_ready;
  logic                 accept;
  logic                 accept_wr;
  logic                 credit_take;
  logic                 pop;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     outstanding_nxt;

  logic                 in_valid;
  logic [LINE_W-1:0]    in_data;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 push;
  logic [LINE_W-1:0]    push_data;
  logic [TAG_WIDTH-1:0] push_tag;

  logic [LINE_W-1:0]    q_data [RSP_QUEUE];
  logic [TAG_WIDTH-1:0] q_tag  [RSP_QUEUE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     q_count;
  logic                 q_empty;
  logic                 head_free;
  logic                 load_from_q;
  logic                 load_from_push;
  logic                 q_push;

  logic                 rsp_valid;
  logic [LINE_W-1:0]    rsp_data;
  logic [TAG_WIDTH-1:0] rsp_tag;

  // Upper address bits are dropped, so addresses alias modulo MEM_DEPTH.
  assign idx       = mem.mem_req_addr[IDX_W-1:0];
  assign accept    = mem.mem_req_valid & req_ready;
  assign accept_wr = accept & mem.mem_req_rw;

`ifdef VX_MEM_RSP_WRITE_ACK_EN
  // Writes return an ack, so they hold a credit just like reads.
  assign credit_take = accept;
`else
  assign credit_take = accept & ~mem.mem_req_rw;
`endif

  // Write acks carry zero data; reads carry the line as it stood before this edge.
  assign in_valid = credit_take;
  assign in_data  = mem.mem_req_rw ? '0 : store[idx];
  assign in_tag   = mem.mem_req_tag;

  // Byte-masked line write on the accept edge; store contents are never reset.
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (mem.mem_req_byteen[b]) begin
          store[idx][b*8 +: 8] <= mem.mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  generate
    if (STAGES == 0) begin : g_no_pipe
      assign push      = in_valid;
      assign push_data = in_data;
      assign push_tag  = in_tag;
    end else begin : g_pipe
      logic [STAGES-1:0]    pipe_valid;
      logic [LINE_W-1:0]    pipe_data [STAGES];
      logic [TAG_WIDTH-1:0] pipe_tag  [STAGES];

      // Valid bits shift every cycle; clearing them drops in-flight responses on reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= in_valid;
          for (int s = 1; s < STAGES; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
          end
        end
      end

      // Payload follows the valid bits; no reset needed on data.
      always_ff @(posedge clk) begin
        pipe_data[0] <= in_data;
        pipe_tag[0]  <= in_tag;
        for (int s = 1; s < STAGES; s++) begin
          pipe_data[s] <= pipe_data[s-1];
          pipe_tag[s]  <= pipe_tag[s-1];
        end
      end

      assign push      = pipe_valid[STAGES-1];
      assign push_data = pipe_data[STAGES-1];
      assign push_tag  = pipe_tag[STAGES-1];
    end
  endgenerate

  // Credit arithmetic: a take and a pop in the same cycle cancel out.
  always_comb begin
    outstanding_nxt = outstanding;
    if (credit_take && !pop) begin
      outstanding_nxt = outstanding + CNT_W'(1);
    end else if (!credit_take && pop) begin
      outstanding_nxt = outstanding - CNT_W'(1);
    end
  end

  // Credit counter and registered request-ready; ready rises one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      req_ready   <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      req_ready   <= (outstanding_nxt < CNT_W'(RSP_QUEUE));
    end
  end

  // The output register is the queue head; the array behind it holds the rest.
  assign pop            = rsp_valid & mem.mem_rsp_ready;
  assign head_free      = ~rsp_valid | pop;
  assign q_empty        = (q_count == '0);
  assign load_from_q    = head_free & ~q_empty;
  assign load_from_push = head_free & q_empty & push;
  assign q_push         = push & ~load_from_push;

  // Queue pointers, occupancy and the head register; head data holds when the queue drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      if (q_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load_from_q) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (q_push && !load_from_q) begin
        q_count <= q_count + CNT_W'(1);
      end else if (!q_push && load_from_q) begin
        q_count <= q_count - CNT_W'(1);
      end
      if (load_from_q) begin
        rsp_valid <= 1'b1;
        rsp_data  <= q_data[rd_ptr];
        rsp_tag   <= q_tag[rd_ptr];
      end else if (load_from_push) begin
        rsp_valid <= 1'b1;
        rsp_data  <= push_data;
        rsp_tag   <= push_tag;
      end else if (pop) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Queue storage; credits keep occupancy below RSP_QUEUE so no full check is needed.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_data[wr_ptr] <= push_data;
      q_tag[wr_ptr]  <= push_tag;
    end
  end

  assign mem.mem_req_ready = req_ready;
  assign mem.mem_rsp_valid = rsp_valid;
  assign mem.mem_rsp_data  = rsp_data;
  assign mem.mem_rsp_tag   = rsp_tag;
  assign busy              = (outstanding != '0);
endmodule

// File: tb/tb_vx_mem_responder.sv
// tb/tb_vx_mem_responder.sv - randomized self-checking bench for vx_mem_responder
module tb_vx_mem_responder;
  localparam int DATA_SIZE  = 64;
  localparam int ADDR_WIDTH = 26;
  localparam int TAG_WIDTH  = 8;
  localparam int MEM_DEPTH  = 1024;
  localparam int LATENCY    = 4;
  localparam int RSP_QUEUE  = 8;
  localparam int LINE_W     = DATA_SIZE * 8;
  localparam int INIT_LINES = 32;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    logic [TAG_WIDTH-1:0] tag;
    line_t                data;
    int                   acc_cyc;
    bit                   chk_lat;
    bit                   seen;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;

  vx_mem_responder_if #(.DATA_SIZE(DATA_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  vx_mem_responder #(
    .DATA_SIZE(DATA_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .LATENCY(LATENCY), .RSP_QUEUE(RSP_QUEUE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    in_reset = 1'b1;
  line_t model_mem [MEM_DEPTH];
  exp_t  expq [$];
  line_t pat_a;
  line_t pat_b;

  task automatic check(string name, line_t got, line_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Compare this cycle's outputs against the reference model.
  task automatic observe();
    exp_t e;
    if (in_reset) begin
      check("rst_ready", line_t'(bus.mem_req_ready), '0);
      check("rst_rsp_valid", line_t'(bus.mem_rsp_valid), '0);
      check("rst_busy", line_t'(busy), '0);
      check("rst_rsp_data", bus.mem_rsp_data, '0);
      check("rst_rsp_tag", line_t'(bus.mem_rsp_tag), '0);
      return;
    end
    check("ready", line_t'(bus.mem_req_ready), line_t'(expq.size() < RSP_QUEUE));
    check("busy", line_t'(busy), line_t'(expq.size() != 0));
    if (bus.mem_rsp_valid) begin
      if (expq.size() == 0) begin
        check("spurious_rsp", line_t'(bus.mem_rsp_valid), '0);
      end else begin
        e = expq[0];
        check("rsp_tag", line_t'(bus.mem_rsp_tag), line_t'(e.tag));
        check("rsp_data", bus.mem_rsp_data, e.data);
        if (!e.seen) begin
          if (e.chk_lat) check("rsp_latency", line_t'(cyc - e.acc_cyc), line_t'(LATENCY));
          e.seen = 1'b1;
          expq[0] = e;
        end
      end
    end else if (expq.size() != 0 && expq[0].chk_lat && (cyc - expq[0].acc_cyc) >= LATENCY) begin
      check("rsp_late", line_t'(bus.mem_rsp_valid), line_t'(1));
    end
  endtask

  // One bus cycle: check outputs, drive inputs, advance the model, clock.
  task automatic step(input bit v, input bit rw, input logic [ADDR_WIDTH-1:0] addr,
                      input line_t data, input logic [DATA_SIZE-1:0] be,
                      input logic [TAG_WIDTH-1:0] tag, input bit rr);
    bit   acc;
    bit   do_pop;
    bit   was_empty;
    int   idx;
    exp_t e;
    observe();
    bus.mem_req_valid  = v;
    bus.mem_req_rw     = rw;
    bus.mem_req_addr   = addr;
    bus.mem_req_data   = data;
    bus.mem_req_byteen = be;
    bus.mem_req_tag    = tag;
    bus.mem_rsp_ready  = rr;
    acc       = v && (expq.size() < RSP_QUEUE);
    do_pop    = bus.mem_rsp_valid && rr && (expq.size() > 0);
    was_empty = (expq.size() == 0);
    if (do_pop) void'(expq.pop_front());
    if (acc) begin
      idx = int'(addr) % MEM_DEPTH;
      e.tag = tag;
      e.acc_cyc = cyc;
      e.chk_lat = was_empty;
      e.seen = 1'b0;
      if (rw) begin
        for (int b = 0; b < DATA_SIZE; b++)
          if (be[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        e.data = '0;
        expq.push_back(e);
`endif
      end else begin
        e.data = model_mem[idx];
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 1'b0, '0, '0, '0, '0, rr);
  endtask

  task automatic do_reset(input int n);
    bus.mem_req_valid = 1'b0;
    bus.mem_rsp_ready = 1'b0;
    reset = 1'b0;
    in_reset = 1'b1;
    expq.delete();
    #1;
    for (int i = 0; i < n; i++) begin
      observe();
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b1;
    observe();
    @(posedge clk);
    #1;
    cyc++;
    in_reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() > 0; i++) idle(1'b1);
    check("drain_empty", line_t'(expq.size()), '0);
  endtask

  initial begin
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_rw     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_byteen = '0;
    bus.mem_req_tag    = '0;
    bus.mem_rsp_ready  = 1'b0;

    do_reset(3);

    for (int i = 0; i < INIT_LINES; i++)
      step(1'b1, 1'b1, ADDR_WIDTH'(i), rand_line(), '1, TAG_WIDTH'(i), 1'b1);
    drain();

    pat_a = rand_line();
    step(1'b1, 1'b1, 26'h10, pat_a, '1, 8'h11, 1'b1);
    drain();
    step(1'b1, 1'b0, 26'h10, '0, '0, 8'h5A, 1'b1);
    drain();

    step(1'b1, 1'b1, 26'h10, line_t'(8'hFF), 64'h1, 8'h12, 1'b1);
    step(1'b1, 1'b1, 26'h11, rand_line(), '0, 8'h13, 1'b1);
    drain();
    step(1'b1, 1'b0, 26'h10, '0, '0, 8'h5B, 1'b1);
    step(1'b1, 1'b0, 26'h11, '0, '0, 8'h5C, 1'b1);
    drain();

    for (int t = 0; t < RSP_QUEUE; t++)
      step(1'b1, 1'b0, ADDR_WIDTH'(t), '0, '0, TAG_WIDTH'(t), 1'b0);
    check("full_ready", line_t'(bus.mem_req_ready), '0);
    step(1'b1, 1'b0, 26'h3, '0, '0, 8'h08, 1'b0);
    idle(1'b0);
    drain();

    pat_b = rand_line();
    step(1'b1, 1'b1, 26'h400, pat_b, '1, 8'h21, 1'b1);
    step(1'b1, 1'b0, 26'h0, '0, '0, 8'h22, 1'b1);
    drain();

    for (int t = 0; t < 3; t++)
      step(1'b1, 1'b0, ADDR_WIDTH'(t + 4), '0, '0, TAG_WIDTH'(8'h40 + t), 1'b0);
    do_reset(2);
    check("post_reset_busy", line_t'(busy), '0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    step(1'b1, 1'b0, 26'h0, '0, '0, 8'h23, 1'b1);
    step(1'b1, 1'b0, 26'h10, '0, '0, 8'h24, 1'b1);
    drain();

`ifdef VX_MEM_RSP_WRITE_ACK_EN
    step(1'b1, 1'b1, 26'h5, rand_line(), '1, 8'h33, 1'b1);
    drain();
`endif

    for (int i = 0; i < 1500; i++) begin
      logic [ADDR_WIDTH-1:0]  a;
      logic [DATA_SIZE-1:0]   be;
      int                     sel;
      a   = ADDR_WIDTH'(($urandom & 32'h03FF_FC00) | ($urandom % INIT_LINES));
      sel = $urandom % 4;
      be  = (sel == 0) ? '0 : (sel == 1) ? '1 : {$urandom, $urandom};
      step(($urandom % 4) != 0, ($urandom % 3) == 0, a, rand_line(), be,
           TAG_WIDTH'($urandom), ($urandom % 4) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
